// File: rtl/brp.sv
// Branch predictor and resolution unit.
// The fetch stage looks up a direct-mapped branch target buffer with 2-bit
// saturating counters; the lookup is combinational, so the prediction is
// ready in the same cycle. The execute stage resolves the branch from the
// comparator flags and funct3, flags a misprediction together with the
// correct next PC, trains the table and keeps saturating statistics.
module brp #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // fetch-side lookup
  input  logic [31:0] i_pc,
  output logic        o_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  // execute-side resolution and training
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [2:0]  i_upd_funct3,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  // statistics
  output logic [15:0] o_br_cnt,
  output logic [15:0] o_miss_cnt
);

  // PC bits [1:0] are never part of index or tag.
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [1:0]  CTR_RESET = 2'b01;
  localparam logic [1:0]  CTR_ALLOC = 2'b10;
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;
  localparam logic [15:0] CNT_ONE   = 16'd1;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True for the six conditional-branch encodings; 010/011 are reserved.
  function automatic logic br_legal(input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Actual outcome. Signedness is already chosen by the comparator, so the
  // signed and unsigned pairs decode identically here.
  function automatic logic br_taken(input logic [2:0] funct3,
                                    input logic       less,
                                    input logic       equal);
    logic taken;
    case (funct3)
      F3_BEQ:  taken = equal;
      F3_BNE:  taken = !equal;
      F3_BLT:  taken = less;
      F3_BGE:  taken = !less;
      F3_BLTU: taken = less;
      F3_BGEU: taken = !less;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // 2-bit saturating counter step: up on taken, down on not-taken.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr,
                                           input logic       taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == CTR_MAX) begin
        nxt = CTR_MAX;
      end else begin
        nxt = ctr + 2'd1;
      end
    end else begin
      if (ctr == CTR_MIN) begin
        nxt = CTR_MIN;
      end else begin
        nxt = ctr - 2'd1;
      end
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic [15:0] br_cnt_r;
  logic [15:0] miss_cnt_r;

  // ---------------------------------------------------------------------------
  // Fetch lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;

  // Asynchronous table read for zero-cycle prediction; no bypass of a
  // same-cycle update, so the pre-update entry is returned.
  always_comb begin
    lk_idx_s     = i_pc[IDX_W+1:2];
    lk_tag_s     = i_pc[31:IDX_W+2];
    lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    o_hit        = lk_hit_s;
    o_pred_taken = lk_hit_s && ctr_r[lk_idx_s][1];
    if (lk_hit_s) begin
      o_pred_target = target_r[lk_idx_s];
    end else begin
      o_pred_target = i_pc + PC_STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // Execute resolution
  // ---------------------------------------------------------------------------
  logic upd_legal_s;
  logic taken_s;

  // Outcome decode, misprediction detect and redirect PC; redirect is always
  // driven so execute can use it without qualifying on the mispredict flag.
  always_comb begin
    upd_legal_s  = i_upd_valid && br_legal(i_upd_funct3);
    taken_s      = br_taken(i_upd_funct3, i_br_less, i_br_equal);
    o_mispredict = upd_legal_s &&
                   ((taken_s != i_upd_pred_taken) ||
                    (taken_s && (i_upd_pred_target != i_upd_target)));
    if (taken_s) begin
      o_redirect_pc = i_upd_target;
    end else begin
      o_redirect_pc = i_upd_pc + PC_STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             wr_en_s;
  logic [31:0]      wr_target_s;
  logic [1:0]       wr_ctr_s;

  // Decide the table write: train on hit, allocate on taken miss (evicting any
  // alias at that index), leave the table alone on a not-taken miss.
  always_comb begin
    up_idx_s    = i_upd_pc[IDX_W+1:2];
    up_tag_s    = i_upd_pc[31:IDX_W+2];
    up_hit_s    = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    wr_en_s     = 1'b0;
    wr_target_s = target_r[up_idx_s];
    wr_ctr_s    = ctr_r[up_idx_s];
    if (upd_legal_s) begin
      if (up_hit_s) begin
        wr_en_s  = 1'b1;
        wr_ctr_s = ctr_train(ctr_r[up_idx_s], taken_s);
        if (taken_s) begin
          wr_target_s = i_upd_target;
        end else begin
          wr_target_s = target_r[up_idx_s];
        end
      end else if (taken_s) begin
        wr_en_s     = 1'b1;
        wr_ctr_s    = CTR_ALLOC;
        wr_target_s = i_upd_target;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table state: reset wins over a same-edge update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'h0000_0000;
        ctr_r[i]    <= CTR_RESET;
      end
    end else if (wr_en_s) begin
      valid_r[up_idx_s]  <= 1'b1;
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= wr_target_s;
      ctr_r[up_idx_s]    <= wr_ctr_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------

  // Saturating branch and misprediction counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_r   <= 16'h0000;
      miss_cnt_r <= 16'h0000;
    end else begin
      if (upd_legal_s && (br_cnt_r != CNT_MAX)) begin
        br_cnt_r <= br_cnt_r + CNT_ONE;
      end
      if (o_mispredict && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

  assign o_br_cnt   = br_cnt_r;
  assign o_miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_brp.sv
// Directed self-checking bench for brp (ENTRIES=16).
module tb_brp;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        o_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic [2:0]  i_upd_funct3;
  logic        i_br_less;
  logic        i_br_equal;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [15:0] o_br_cnt;
  logic [15:0] o_miss_cnt;

  int checks = 0;
  int errors = 0;

  brp #(.ENTRIES(16)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_pc              (i_pc),
    .o_hit             (o_hit),
    .o_pred_taken      (o_pred_taken),
    .o_pred_target     (o_pred_target),
    .i_upd_valid       (i_upd_valid),
    .i_upd_pc          (i_upd_pc),
    .i_upd_funct3      (i_upd_funct3),
    .i_br_less         (i_br_less),
    .i_br_equal        (i_br_equal),
    .i_upd_target      (i_upd_target),
    .i_upd_pred_taken  (i_upd_pred_taken),
    .i_upd_pred_target (i_upd_pred_target),
    .o_mispredict      (o_mispredict),
    .o_redirect_pc     (o_redirect_pc),
    .o_br_cnt          (o_br_cnt),
    .o_miss_cnt        (o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then step off it before touching inputs or sampling.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [2:0] f3, input logic less,
                     input logic equal, input logic [31:0] tgt, input logic pt,
                     input logic [31:0] ptgt);
    i_upd_valid       = 1'b1;
    i_upd_pc          = pc;
    i_upd_funct3      = f3;
    i_br_less         = less;
    i_br_equal        = equal;
    i_upd_target      = tgt;
    i_upd_pred_taken  = pt;
    i_upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    i_upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    i_pc = pc;
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_pc = 32'h0; i_upd_valid = 1'b0; i_upd_pc = 32'h0;
    i_upd_funct3 = 3'b000; i_br_less = 1'b0; i_br_equal = 1'b0;
    i_upd_target = 32'h0; i_upd_pred_taken = 1'b0; i_upd_pred_target = 32'h0;
    tick(); tick();
    i_rst = 1'b0;

    // After reset
    look(32'h100);
    check("rst_hit", o_hit, 32'd0);
    check("rst_pred_taken", o_pred_taken, 32'd0);
    check("rst_pred_target", o_pred_target, 32'h104);
    check("rst_br_cnt", o_br_cnt, 32'd0);
    check("rst_miss_cnt", o_miss_cnt, 32'd0);

    // Allocate on taken BEQ predicted not-taken
    upd(32'h100, 3'b000, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    check("alloc_mispredict", o_mispredict, 32'd1);
    check("alloc_redirect", o_redirect_pc, 32'h80);
    check("alloc_nobypass_hit", o_hit, 32'd0);
    tick(); idle();
    check("alloc_hit", o_hit, 32'd1);
    check("alloc_pred_taken", o_pred_taken, 32'd1);
    check("alloc_target", o_pred_target, 32'h80);
    check("alloc_miss_cnt", o_miss_cnt, 32'd1);
    check("alloc_br_cnt", o_br_cnt, 32'd1);

    // Hysteresis: BNE with equal=1 is not taken; ctr 10 -> 01
    upd(32'h100, 3'b001, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    check("bne_mispredict", o_mispredict, 32'd1);
    check("bne_redirect", o_redirect_pc, 32'h104);
    tick(); idle();
    check("ctr01_hit", o_hit, 32'd1);
    check("ctr01_pred_taken", o_pred_taken, 32'd0);
    // Correctly predicted taken: 01 -> 10 -> 11 -> 11
    upd(32'h100, 3'b000, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    check("taken_ok_mispredict", o_mispredict, 32'd0);
    tick();
    check("ctr10_pred_taken", o_pred_taken, 32'd1);
    tick(); tick();
    // Two not-taken from saturated 11: 11 -> 10 (still taken) -> 01
    upd(32'h100, 3'b001, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    check("ctr_sat_pred_taken", o_pred_taken, 32'd1);
    tick(); idle();
    check("ctr_down_pred_taken", o_pred_taken, 32'd0);
    check("hyst_br_cnt", o_br_cnt, 32'd7);
    check("hyst_miss_cnt", o_miss_cnt, 32'd4);

    // Aliasing: 0x140 shares index 0 with 0x100
    upd(32'h140, 3'b000, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    tick(); idle();
    look(32'h100);
    check("alias_old_hit", o_hit, 32'd0);
    check("alias_old_target", o_pred_target, 32'h104);
    look(32'h140);
    check("alias_new_hit", o_hit, 32'd1);
    check("alias_new_target", o_pred_target, 32'h300);
    check("alias_new_pred", o_pred_taken, 32'd1);
    // Not-taken at a missing PC leaves the table alone
    upd(32'h100, 3'b001, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0);
    check("nt_miss_mispredict", o_mispredict, 32'd0);
    tick(); idle();
    check("nt_miss_keep_hit", o_hit, 32'd1);
    check("nt_miss_keep_target", o_pred_target, 32'h300);
    look(32'h100);
    check("nt_miss_no_alloc", o_hit, 32'd0);
    check("nt_miss_br_cnt", o_br_cnt, 32'd9);
    check("nt_miss_miss_cnt", o_miss_cnt, 32'd5);

    // Target mismatch on BGEU (less=0 -> taken)
    upd(32'h404, 3'b111, 1'b0, 1'b0, 32'h204, 1'b1, 32'h200);
    check("tgt_mispredict", o_mispredict, 32'd1);
    check("tgt_redirect", o_redirect_pc, 32'h204);
    tick(); idle();
    look(32'h404);
    check("tgt_alloc_target", o_pred_target, 32'h204);
    // BLT less=1 correctly predicted
    upd(32'h408, 3'b100, 1'b1, 1'b0, 32'h500, 1'b1, 32'h500);
    check("blt_mispredict", o_mispredict, 32'd0);
    // BGE less=1 not taken, predicted taken
    upd(32'h408, 3'b101, 1'b1, 1'b0, 32'h500, 1'b1, 32'h500);
    check("bge_mispredict", o_mispredict, 32'd1);
    check("bge_redirect", o_redirect_pc, 32'h40C);
    // BLTU less=0 not taken, predicted not taken
    upd(32'h408, 3'b110, 1'b0, 1'b0, 32'h500, 1'b0, 32'h0);
    check("bltu_mispredict", o_mispredict, 32'd0);

    // Illegal funct3 with valid=1
    upd(32'h10C, 3'b010, 1'b1, 1'b1, 32'h700, 1'b1, 32'h600);
    check("ill010_mispredict", o_mispredict, 32'd0);
    tick();
    upd(32'h10C, 3'b011, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
    check("ill011_mispredict", o_mispredict, 32'd0);
    tick(); idle();
    look(32'h10C);
    check("ill_no_alloc", o_hit, 32'd0);
    check("ill_br_cnt", o_br_cnt, 32'd10);
    check("ill_miss_cnt", o_miss_cnt, 32'd6);

    // Reset priority over a same-edge taken update
    i_rst = 1'b1;
    upd(32'h20C, 3'b000, 1'b0, 1'b1, 32'h880, 1'b0, 32'h0);
    check("rstcomb_mispredict", o_mispredict, 32'd1);
    check("rstcomb_redirect", o_redirect_pc, 32'h880);
    tick();
    i_rst = 1'b0;
    idle();
    look(32'h20C);
    check("rstpri_no_alloc", o_hit, 32'd0);
    look(32'h140);
    check("rstpri_cleared", o_hit, 32'd0);
    check("rstpri_br_cnt", o_br_cnt, 32'd0);
    check("rstpri_miss_cnt", o_miss_cnt, 32'd0);

    // PC wrap
    upd(32'hFFFF_FFFC, 3'b000, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0);
    check("wrap_redirect", o_redirect_pc, 32'h0);
    look(32'hFFFF_FFFC);
    check("wrap_pred_target", o_pred_target, 32'h0);

    // Saturation: continuous correctly predicted not-taken branches
    repeat (65534) @(posedge i_clk);
    #1;
    check("sat_br_cnt_fffe", o_br_cnt, 32'hFFFE);
    tick();
    check("sat_br_cnt_ffff", o_br_cnt, 32'hFFFF);
    tick(); tick();
    check("sat_br_cnt_hold", o_br_cnt, 32'hFFFF);
    check("sat_miss_cnt", o_miss_cnt, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brp.md
# brp

Branch predictor and resolution unit for the RISC-V core. Looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters at fetch and predicts taken/target. Consumes the branch comparator's `less`/`equal` flags at execute, decodes the actual outcome from funct3, and flags mispredictions with the redirect PC. Trains the table and keeps saturating performance counters.

## Interface
- `ENTRIES`, default 16: BTB entries; power of two, ≥2.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, do not override.

- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_pc`, in, 32: fetch PC for lookup.
- `o_hit`, out, 1: valid entry with matching tag at `i_pc`.
- `o_pred_taken`, out, 1: prediction; `o_hit && ctr[1]`.
- `o_pred_target`, out, 32: stored target on hit, else `i_pc+4`.
- `i_upd_valid`, in, 1: branch at execute this cycle.
- `i_upd_pc`, in, 32: PC of the resolving branch.
- `i_upd_funct3`, in, 3: branch funct3.
- `i_br_less`, in, 1: comparator less-than flag. Signedness is already selected by the comparator.
- `i_br_equal`, in, 1: comparator equality flag.
- `i_upd_target`, in, 32: computed branch target.
- `i_upd_pred_taken`, in, 1: prediction carried down the pipe.
- `i_upd_pred_target`, in, 32: predicted target carried down the pipe.
- `o_mispredict`, out, 1: execute must flush and redirect.
- `o_redirect_pc`, out, 32: correct next PC.
- `o_br_cnt`, out, 16: resolved legal branches, saturating.
- `o_miss_cnt`, out, 16: mispredictions, saturating.

## Operation
- **Indexing**
  - Index = `pc[IDX_W+1:2]`.
  - Tag = `pc[31:IDX_W+2]`.
  - Each entry holds valid, tag, 32-bit target and a 2-bit counter.
- **Outcome decode** (`taken`)
  - 000 BEQ = equal.
  - 001 BNE = !equal.
  - 100 BLT = less.
  - 101 BGE = !less.
  - 110 BLTU = less.
  - 111 BGEU = !less.
  - 010 and 011 are illegal. When illegal and `i_upd_valid=1`: no table write, no counter change, `o_mispredict=0`.
- **Mispredict**
  - `o_mispredict = upd_legal && (taken != i_upd_pred_taken || (taken && i_upd_pred_target != i_upd_target))`.
  - `o_redirect_pc = taken ? i_upd_target : i_upd_pc+4`. It is driven even when `o_mispredict=0`.
- **Training** (on legal update)
  - Hit at `i_upd_pc`: counter increments on taken (saturates at 3) and decrements on not-taken (saturates at 0). Target is overwritten only when taken.
  - Miss, taken: allocate the entry, overwriting any occupant. Set valid=1, tag, target, counter=2'b10.
  - Miss, not-taken: no write.
- **Statistics**
  - `o_br_cnt` +1 per legal update.
  - `o_miss_cnt` +1 per mispredict.
  - Both hold at 16'hFFFF once saturated.

## Timing
- Lookup and resolution outputs are combinational from current state and inputs. This gives zero-cycle prediction, with the table read asynchronously.
- Table and counter writes take effect at the rising edge after `i_upd_valid`. The updated entry is visible to lookup the next cycle.
- A same-cycle lookup of the index being updated returns pre-update contents; there is no bypass.
- Reset values:
  - All valid bits 0 and all counters 2'b01; tags and targets cleared to 0.
  - `o_br_cnt` and `o_miss_cnt` are 0.
  - With all entries invalid: `o_hit=0`, `o_pred_taken=0`, `o_pred_target=i_pc+4`.
  - `o_mispredict` and `o_redirect_pc` remain combinational from inputs during reset.
- `i_rst` has priority over a simultaneous update. The update is discarded and reset state is loaded at that edge.
- `i_pc+4` and `i_upd_pc+4` wrap modulo 2^32 (0xFFFFFFFC → 0x00000000).
- One update per cycle. Any `i_upd_pc` is accepted; low bits [1:0] are ignored.

## Test plan
- **After reset:** `i_pc=0x100` → `o_hit=0`, `o_pred_taken=0`, `o_pred_target=0x104`, both counters 0.
- **Allocate and predict:**
  - Update pc=0x100, funct3=000, equal=1, target=0x80, pred_taken=0 → `o_mispredict=1`, `o_redirect_pc=0x80`.
  - Next cycle lookup 0x100 → hit, `pred_taken=1`, target 0x80, `o_miss_cnt=1`.
- **Counter hysteresis:**
  - From counter=2'b10, one not-taken BNE (equal=1) → counter 2'b01, `pred_taken=0`, mispredict asserted.
  - Two taken updates → counter 2'b11. A third taken update → stays 2'b11.
- **Aliasing:**
  - Allocate pc=0x100, then taken update at 0x140 (ENTRIES=16, same index, different tag) → lookup 0x100 misses, 0x140 hits.
  - Not-taken update at a missing PC leaves the table unchanged.
- **Target mismatch and illegal funct3:**
  - BGEU with less=0, pred_taken=1, pred_target=0x200, target=0x204 → `o_mispredict=1`, redirect 0x204.
  - funct3=010 with `i_upd_valid=1` → `o_mispredict=0`, `o_br_cnt` unchanged.
- **Reset priority and wrap:**
  - Assert `i_rst` on the same edge as a taken update → entry not allocated.
  - Update pc=0xFFFFFFFC, not-taken → `o_redirect_pc=0x00000000`.
  - Force 65535 branches → `o_br_cnt` holds 0xFFFF.
